sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO, the next generation of the team's 8x16 register FIFO. Width and depth are configurable. It uses the full DEPTH entries: full means count == DEPTH. It adds an occupancy count, programmable almost-full/almost-empty flags, a read-valid strobe, sticky overflow/underflow error flags and a synchronous flush. Simultaneous read and write are defined at the full and empty boundaries. It sits between a producer and a consumer in the same clock domain.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 16, number of entries; any value >= 2, power of two not required
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
CW (derived), $clog2(DEPTH+1), count width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush; empties the FIFO and clears error flags
writesignal  input  1  write request
data_in  input  DATA_WIDTH  write data
readsignal  input  1  read request
data_out  output  DATA_WIDTH  registered read data
data_valid  output  1  one-cycle strobe: data_out updated by an accepted read
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  CW  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Interface decided: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n low, any time, including mid-operation):
  - write pointer, read pointer, count and data_out are 0; data_valid, overflow and underflow are 0.
  - Therefore empty=1, full=0, almost_full=(AF_LEVEL==0? never), almost_empty=1.
  - Storage contents are not reset and are don't-care.
  - Release is sampled on the next rising clk.
- clear has priority over reads and writes in the same cycle:
  - pointers and count go to 0, and overflow, underflow and data_valid go to 0.
  - data_out holds its value.
- Acceptance is evaluated on the pre-edge state:
  - wr_acc = writesignal & (!full | readsignal)
  - rd_acc = readsignal & !empty
- Write only accepted:
  - mem[wptr] <= data_in; wptr advances; count +1.
- Read only accepted:
  - data_out <= mem[rptr] on the same edge; data_valid=1 for the following cycle; rptr advances; count -1.
  - Read latency is 1 cycle from the request edge.
- Both accepted: read and write occur, both pointers advance, count is unchanged.
  - When full, a simultaneous read+write is legal; the write lands in the slot being freed and data_out gets the old head.
- Write + read while empty: only the write is accepted.
  - count becomes 1, data_valid=0, and underflow is set.
  - There is no fall-through.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. This holds for non-power-of-two DEPTH.
- Overflow: writesignal & full & !readsignal rejects the write, storage and count are unchanged, and overflow is set.
- Underflow: readsignal & empty rejects the read, data_out holds, and underflow is set.
- overflow and underflow stay set until rst_n or clear.
- data_valid is 0 in any cycle that follows a non-accepted read; data_out holds otherwise.
- Status flags are combinational from the count register, with no extra latency. All flags are consistent with count in every cycle.
- count never exceeds DEPTH and never goes below 0.

Test Plan:
(All defaults: DATA_WIDTH=8, DEPTH=16, AF=12, AE=4.)
1. Reset, then write 0x01..0x10 over 16 cycles, then read 16 -> data_out is 0x01..0x10 in order, each one cycle after its read request with data_valid=1. count goes 16 then 0; full=1 only at count 16; almost_full from count 12; almost_empty at count <=4.
2. Fill to 16, write 0xAA without read -> write rejected, overflow=1, count=16. Drain 16 -> 0xAA is never output; overflow stays 1 until clear.
3. Empty FIFO, assert read + write of 0x5C together -> count=1, data_valid=0, underflow=1. Next cycle read -> data_out=0x5C.
4. Full FIFO (0x00..0x0F), simultaneous read+write of 0xF0 for 20 cycles -> count stays 16; outputs 0x00..0x0F then 0xF0; pointers wrap with no loss.
5. DEPTH=5 instance: 3 rounds of write 5 / read 5 with distinct data -> order preserved across the non-power-of-two wrap; full at 5.
6. Write 7 entries, pulse rst_n low asynchronously mid-cycle during a read -> outputs go to reset values immediately without a clock edge. Then apply clear with read+write asserted on a 3-entry FIFO -> count=0, empty=1, nothing written.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, a
// read-valid strobe, sticky overflow/underflow flags and a synchronous flush.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  writesignal,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  readsignal,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]         wptr_r;
  logic [PW-1:0]         rptr_r;
  logic [CW-1:0]         count_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  data_valid_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  // Explicit wrap so non-power-of-two depths never touch a slot >= DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    logic [PW-1:0] nxt;
    if (ptr == PW'(DEPTH - 1)) begin
      nxt = '0;
    end else begin
      nxt = ptr + PW'(1);
    end
    return nxt;
  endfunction

  // Status flags and acceptance decode from the pre-edge occupancy.
  always_comb begin
    full_s   = (count_r == CW'(DEPTH));
    empty_s  = (count_r == '0);
    wr_acc_s = writesignal & (~full_s | readsignal);
    rd_acc_s = readsignal & ~empty_s;
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s && !clear) begin
      mem_r[wptr_r] <= data_in;
    end
  end

  // Pointers, occupancy, read data and sticky error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r       <= '0;
      rptr_r       <= '0;
      count_r      <= '0;
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else if (clear) begin
      wptr_r       <= '0;
      rptr_r       <= '0;
      count_r      <= '0;
      data_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wptr_r <= ptr_inc(wptr_r);
      end
      if (rd_acc_s) begin
        rptr_r     <= ptr_inc(rptr_r);
        data_out_r <= mem_r[rptr_r];
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      data_valid_r <= rd_acc_s;
      overflow_r   <= overflow_r | (writesignal & full_s & ~readsignal);
      underflow_r  <= underflow_r | (readsignal & empty_s);
    end
  end

  assign data_out     = data_out_r;
  assign data_valid   = data_valid_r;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= CW'(AF_LEVEL));
  assign almost_empty = (count_r <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a default 16-deep instance and a 5-deep instance
// share stimulus; a queue model predicts the outputs of whichever is selected.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       writesignal;
  logic [7:0] data_in;
  logic       readsignal;

  logic [7:0] a_data_out, b_data_out;
  logic       a_data_valid, b_data_valid;
  logic       a_full, b_full, a_empty, b_empty;
  logic       a_almost_full, b_almost_full, a_almost_empty, b_almost_empty;
  logic [4:0] a_count;
  logic [2:0] b_count;
  logic       a_overflow, b_overflow, a_underflow, b_underflow;

  sync_fifo_param dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .writesignal(writesignal), .data_in(data_in), .readsignal(readsignal),
    .data_out(a_data_out), .data_valid(a_data_valid),
    .full(a_full), .empty(a_empty),
    .almost_full(a_almost_full), .almost_empty(a_almost_empty),
    .count(a_count), .overflow(a_overflow), .underflow(a_underflow)
  );

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .writesignal(writesignal), .data_in(data_in), .readsignal(readsignal),
    .data_out(b_data_out), .data_valid(b_data_valid),
    .full(b_full), .empty(b_empty),
    .almost_full(b_almost_full), .almost_empty(b_almost_empty),
    .count(b_count), .overflow(b_overflow), .underflow(b_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit active = 1'b0;

  logic [7:0] mq[$];
  int         m_depth = 16;
  int         m_af = 12;
  int         m_ae = 4;
  logic [7:0] m_dout = 8'h00;
  logic       m_dv = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = 8'h00;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_step(input logic wr, input logic [7:0] d, input logic rd, input logic cl);
    bit was_full;
    bit was_empty;
    if (cl) begin
      mq.delete();
      m_dv  = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      was_full  = (mq.size() == m_depth);
      was_empty = (mq.size() == 0);
      m_dv = 1'b0;
      if (rd && !was_empty) begin
        m_dout = mq.pop_front();
        m_dv   = 1'b1;
      end
      if (wr && (!was_full || rd)) mq.push_back(d);
      if (wr && was_full && !rd) m_ovf = 1'b1;
      if (rd && was_empty) m_unf = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".data_out"}, active ? 32'(b_data_out) : 32'(a_data_out), 32'(m_dout));
    chk({tag, ".data_valid"}, active ? 32'(b_data_valid) : 32'(a_data_valid), 32'(m_dv));
    chk({tag, ".count"}, active ? 32'(b_count) : 32'(a_count), 32'(n));
    chk({tag, ".full"}, active ? 32'(b_full) : 32'(a_full), 32'(n == m_depth));
    chk({tag, ".empty"}, active ? 32'(b_empty) : 32'(a_empty), 32'(n == 0));
    chk({tag, ".almost_full"}, active ? 32'(b_almost_full) : 32'(a_almost_full), 32'(n >= m_af));
    chk({tag, ".almost_empty"}, active ? 32'(b_almost_empty) : 32'(a_almost_empty), 32'(n <= m_ae));
    chk({tag, ".overflow"}, active ? 32'(b_overflow) : 32'(a_overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, active ? 32'(b_underflow) : 32'(a_underflow), 32'(m_unf));
  endtask

  task automatic cyc(input logic wr, input logic [7:0] d, input logic rd, input logic cl, input string tag);
    writesignal = wr;
    data_in     = d;
    readsignal  = rd;
    clear       = cl;
    @(posedge clk);
    model_step(wr, d, rd, cl);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    writesignal = 1'b0;
    readsignal  = 1'b0;
    clear       = 1'b0;
    data_in     = 8'h00;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int ncyc, input string tag);
    int pw;
    int pr;
    for (int i = 0; i < ncyc; i++) begin
      case ((i / 40) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        default: begin pw = 60; pr = 60; end
      endcase
      cyc(logic'($urandom_range(0, 99) < pw), 8'($urandom_range(0, 255)),
          logic'($urandom_range(0, 99) < pr), logic'($urandom_range(0, 59) == 0), tag);
    end
  endtask

  initial begin
    // ---------------- 16-deep instance ----------------
    active = 1'b0; m_depth = 16; m_af = 12; m_ae = 4;
    do_reset("a.reset");

    for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, "a.t1.wr");
    chk("a.t1.full_at_16", 32'(a_full), 32'd1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "a.t1.rd");
    cyc(1'b0, 8'h00, 1'b0, 1'b0, "a.t1.idle");

    for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom_range(0, 169)), 1'b0, 1'b0, "a.t2.fill");
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, "a.t2.reject");
    chk("a.t2.overflow_set", 32'(a_overflow), 32'd1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "a.t2.drain");
    cyc(1'b0, 8'h00, 1'b0, 1'b0, "a.t2.sticky");
    cyc(1'b0, 8'h00, 1'b0, 1'b1, "a.t2.clear");

    cyc(1'b1, 8'h5C, 1'b1, 1'b0, "a.t3.rw_empty");
    chk("a.t3.underflow_set", 32'(a_underflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "a.t3.read");
    chk("a.t3.data", 32'(a_data_out), 32'h5C);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, "a.t3.clear");

    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, "a.t4.fill");
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'hF0, 1'b1, 1'b0, "a.t4.rw_full");
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "a.t4.drain");

    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, "a.t6.fill");
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "a.t6.read");
    readsignal = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("a.t6.async_rst");
    chk("a.t6.async_rst_count", 32'(a_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    readsignal = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "a.t6.fill3");
    cyc(1'b1, 8'h77, 1'b1, 1'b1, "a.t6.clear_rw");
    cyc(1'b0, 8'h00, 1'b0, 1'b0, "a.t6.idle");
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "a.t6.read_empty");

    random_phase(400, "a.rand");

    // ---------------- 5-deep instance ----------------
    active = 1'b1; m_depth = 5; m_af = 4; m_ae = 1;
    do_reset("b.reset");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(r * 16 + i + 1), 1'b0, 1'b0, "b.t5.wr");
      chk("b.t5.full_at_5", 32'(b_full), 32'd1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "b.t5.rd");
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "b.fill");
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, "b.reject");
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0, "b.rw_full");
    random_phase(300, "b.rand");

    writesignal = 1'b0;
    readsignal  = 1'b0;
    clear       = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
